// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared size encodings, LSU FSM states and lane-mask helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Wide enough for two adjacent words of up to 16 lanes each.
  localparam int MASK_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      default: return 4'd4;
    endcase
  endfunction

  // Bits [LANES-1:0] select lanes of word N, the next LANES bits those of word N+1.
  function automatic logic [MASK_W-1:0] lane_mask(input logic [1:0] size, input logic [3:0] off);
    logic [MASK_W-1:0] m;
    case (size)
      SZ_B:    m = 32'h0000_0001;
      SZ_H:    m = 32'h0000_0003;
      default: m = 32'h0000_000F;
    endcase
    return m << off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
// ============================================================================
// Module   : dmem_bank
// Brief    : Word RAM with per-byte-lane write enables and a registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = DATA_WIDTH / 8,
  parameter int WORD_AW    = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  input  logic [LANES-1:0]      we_i,
  input  logic [WORD_AW-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** WORD_AW;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int l = 0; l < LANES; l++) begin
        if (we_i[l]) begin
          mem_q[addr_i][l*8 +: 8] <= wdata_i[l*8 +: 8];
        end
      end
    end
  end

  // Read-before-write on the same edge; a store is visible to the next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
// Module   : dmem_lsu
// Brief    : RV32 load/store unit over a byte-lane data bank (MEM stage).
// Config   : DMEM_MISALIGN_SPLIT_EN splits misaligned accesses over two words;
//            when undefined they are rejected with rsp_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_uns,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int WAW   = ADDR_WIDTH - OFFW;

  // Request decode
  logic [OFFW-1:0]         w_off;
  logic [WAW-1:0]          w_widx;
  logic [3:0]              w_nbytes;
  logic                    w_misalign;
  logic [MASK_W-1:0]       w_mask_full;
  logic [2*LANES-1:0]      w_mask;
  logic [2*DATA_WIDTH-1:0] w_wide;
  logic                    w_accept;

  assign w_off       = req_addr[OFFW-1:0];
  assign w_widx      = req_addr[ADDR_WIDTH-1:OFFW];
  assign w_nbytes    = size_bytes(req_size);
  assign w_misalign  = |(4'(w_off) & (w_nbytes - 4'd1));
  assign w_mask_full = lane_mask(req_size, 4'(w_off));
  assign w_mask      = w_mask_full[2*LANES-1:0];
  assign w_wide      = {{DATA_WIDTH{1'b0}}, req_wdata} << {w_off, 3'b000};
  assign w_accept    = req_valid & req_ready;

  generate
    if (2 * LANES < MASK_W) begin : g_mask_sink
      logic w_unused_mask;
      assign w_unused_mask = ^w_mask_full[MASK_W-1:2*LANES];
    end
  endgenerate

  // Bank port
  logic                  w_bank_en;
  logic [LANES-1:0]      w_bank_we;
  logic [WAW-1:0]        w_bank_addr;
  logic [DATA_WIDTH-1:0] w_bank_wdata;
  logic [DATA_WIDTH-1:0] w_bank_rdata;

  dmem_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .WORD_AW    (WAW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (w_bank_en),
    .we_i    (w_bank_we),
    .addr_i  (w_bank_addr),
    .wdata_i (w_bank_wdata),
    .rdata_o (w_bank_rdata)
  );

  // Request attributes kept for shaping the response
  logic [1:0]      size_q;
  logic [OFFW-1:0] off_q;
  logic            uns_q;
  logic            load_q;
  logic            rsp_valid_q;
  logic            w_rsp_fire;
  logic            w_err_out;
  logic [DATA_WIDTH-1:0] w_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q      <= SZ_B;
      off_q       <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= w_rsp_fire;
      if (w_accept) begin
        size_q <= req_size;
        off_q  <= w_off;
        uns_q  <= req_uns;
        load_q <= ~req_we;
      end
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  state_e                state_q, state_d;
  logic [WAW-1:0]        p1_addr_q;
  logic [LANES-1:0]      p1_we_q;
  logic [DATA_WIDTH-1:0] p1_wdata_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  split_q;
  logic [2*DATA_WIDTH-1:0] w_pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p1_addr_q  <= '0;
      p1_we_q    <= '0;
      p1_wdata_q <= '0;
      lo_q       <= '0;
      split_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      split_q <= (state_q == SPLIT);
      if (state_q == IDLE && w_accept) begin
        p1_addr_q  <= w_widx + WAW'(1);
        p1_we_q    <= w_mask[2*LANES-1:LANES] & {LANES{req_we}};
        p1_wdata_q <= w_wide[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      // Phase-0 word is still in the bank output register at the phase-1 edge.
      if (state_q == SPLIT) begin
        lo_q <= w_bank_rdata;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    w_bank_en    = 1'b0;
    w_bank_we    = '0;
    w_bank_addr  = w_widx;
    w_bank_wdata = w_wide[DATA_WIDTH-1:0];
    w_rsp_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          w_bank_en = 1'b1;
          w_bank_we = w_mask[LANES-1:0] & {LANES{req_we}};
          if (w_misalign) begin
            state_d = SPLIT;
          end else begin
            w_rsp_fire = 1'b1;
          end
        end
      end
      SPLIT: begin
        w_bank_en    = 1'b1;
        w_bank_we    = p1_we_q;
        w_bank_addr  = p1_addr_q;
        w_bank_wdata = p1_wdata_q;
        w_rsp_fire   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign w_err_out = 1'b0;
  assign rsp_err   = 1'b0;
  assign w_pair    = split_q ? {w_bank_rdata, lo_q} : {{DATA_WIDTH{1'b0}}, w_bank_rdata};

  logic [2*DATA_WIDTH-1:0] w_pair_sh;
  logic [DATA_WIDTH-1:0]   w_unused_pair;
  assign w_pair_sh     = w_pair >> {off_q, 3'b000};
  assign w_raw         = w_pair_sh[DATA_WIDTH-1:0];
  assign w_unused_pair = w_pair_sh[2*DATA_WIDTH-1:DATA_WIDTH];
`else
  logic rsp_err_q;
  logic w_unused_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= w_accept & w_misalign;
    end
  end

  always_comb begin
    w_bank_en    = w_accept;
    w_bank_we    = '0;
    w_bank_addr  = w_widx;
    w_bank_wdata = w_wide[DATA_WIDTH-1:0];
    w_rsp_fire   = w_accept;
    if (req_we && !w_misalign) begin
      w_bank_we = w_mask[LANES-1:0];
    end
  end

  // Aligned accesses never reach into the following word.
  assign w_unused_hi = ^{w_mask[2*LANES-1:LANES], w_wide[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign req_ready   = 1'b1;
  assign w_err_out   = rsp_err_q;
  assign rsp_err     = rsp_err_q;
  assign w_raw       = w_bank_rdata >> {off_q, 3'b000};
`endif

  // Mask to the access size, then sign- or zero-extend.
  logic [DATA_WIDTH-1:0] w_ext;
  logic                  w_sign;
  int                    w_nbits;

  always_comb begin
    w_ext   = '0;
    w_nbits = 8 * int'(size_bytes(size_q));
    case (size_q)
      SZ_B:    w_sign = ~uns_q & w_raw[7];
      SZ_H:    w_sign = ~uns_q & w_raw[15];
      default: w_sign = ~uns_q & w_raw[31];
    endcase
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_ext[i] = (i < w_nbits) ? w_raw[i] : w_sign;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (rsp_valid_q && load_q && !w_err_out) ? w_ext : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Directed self-checking bench for dmem_lsu (either misalign build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  dmem_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_uns   (req_uns),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, accepted at the next rising edge; returns 1 ns after it.
  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [10:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_uns   = uns;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                    input logic [10:0] addr, input logic [31:0] exp);
    drive(1'b0, size, uns, addr, 32'h0);
    chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " err"}, 32'(rsp_err), 32'd0);
    chk(tag, rsp_rdata, exp);
  endtask

  task automatic st(input string tag, input logic [1:0] size,
                    input logic [10:0] addr, input logic [31:0] wd);
    drive(1'b1, size, 1'b0, addr, wd);
    chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " rdata"}, rsp_rdata, 32'h0);
  endtask

`ifdef DMEM_MISALIGN_SPLIT_EN
  task automatic split(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [10:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp);
    drive(we, size, uns, addr, wd);
    chk({tag, " ready0"}, 32'(req_ready), 32'd0);
    chk({tag, " early"}, 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " err"}, 32'(rsp_err), 32'd0);
    chk({tag, " ready1"}, 32'(req_ready), 32'd1);
    chk(tag, rsp_rdata, exp);
  endtask
`else
  task automatic mis(input string tag, input logic we, input logic [1:0] size,
                     input logic [10:0] addr);
    drive(we, size, 1'b0, addr, 32'hFFFF_FFFF);
    chk({tag, " valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " err"}, 32'(rsp_err), 32'd1);
    chk({tag, " rdata"}, rsp_rdata, 32'h0);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
  endtask
`endif

  initial begin
    #12;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'h0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    st("sw 010", W, 11'h010, 32'hDEAD_BEEF);
    ld("lw 010", W, 1'b0, 11'h010, 32'hDEAD_BEEF);

    st("sb 013", B, 11'h013, 32'h0000_0080);
    ld("lb 013", B, 1'b0, 11'h013, 32'hFFFF_FF80);
    ld("lbu 013", B, 1'b1, 11'h013, 32'h0000_0080);
    ld("lw 010 after sb", W, 1'b0, 11'h010, 32'h80AD_BEEF);

    st("sh 012", H, 11'h012, 32'h0000_1234);
    ld("lhu 012", H, 1'b1, 11'h012, 32'h0000_1234);
    ld("lh 010", H, 1'b0, 11'h010, 32'hFFFF_BEEF);
    ld("lh 012 positive", H, 1'b0, 11'h012, 32'h0000_1234);

    st("sw 010 again", W, 11'h010, 32'h80AD_BEEF);
    st("sb 014", B, 11'h014, 32'h0000_0034);

`ifdef DMEM_MISALIGN_SPLIT_EN
    split("lw 011 split", 1'b0, W, 1'b0, 11'h011, 32'h0, 32'h3480_ADBE);
    split("sw 7fe wrap", 1'b1, W, 1'b0, 11'h7FE, 32'hA1B2_C3D4, 32'h0);
    ld("lbu 7fe", B, 1'b1, 11'h7FE, 32'h0000_00D4);
    ld("lbu 7ff", B, 1'b1, 11'h7FF, 32'h0000_00C3);
    ld("lbu 000", B, 1'b1, 11'h000, 32'h0000_00B2);
    ld("lbu 001", B, 1'b1, 11'h001, 32'h0000_00A1);
    split("lw 7fe wrap", 1'b0, W, 1'b0, 11'h7FE, 32'h0, 32'hA1B2_C3D4);
    split("lh 013 signed", 1'b0, H, 1'b0, 11'h013, 32'h0, 32'h0000_3480);

    st("sw 020", W, 11'h020, 32'h1111_1111);
    st("sw 024", W, 11'h024, 32'h2222_2222);
    drive(1'b1, W, 1'b0, 11'h022, 32'hAABB_CCDD);
    chk("split rst ready0", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #2;
    chk("split rst valid", 32'(rsp_valid), 32'd0);
    chk("split rst ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("split rst no rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst ready", 32'(req_ready), 32'd1);
    chk("post rst valid", 32'(rsp_valid), 32'd0);
    ld("lw 020 phase0 kept", W, 1'b0, 11'h020, 32'hCCDD_1111);
    ld("lw 024 phase1 dropped", W, 1'b0, 11'h024, 32'h2222_2222);
`else
    mis("lw 011 mis", 1'b0, W, 11'h011);
    mis("sw 011 mis", 1'b1, W, 11'h011);
    mis("sh 013 mis", 1'b1, H, 11'h013);
    mis("lh 7ff mis", 1'b0, H, 11'h7FF);
    ld("lw 010 unchanged", W, 1'b0, 11'h010, 32'h80AD_BEEF);
    ld("lbu 014 unchanged", B, 1'b1, 11'h014, 32'h0000_0034);
    st("sh 7fe", H, 11'h7FE, 32'h0000_BEEF);
    ld("lhu 7fe", H, 1'b1, 11'h7FE, 32'h0000_BEEF);
    ld("lh 7fe", H, 1'b0, 11'h7FE, 32'hFFFF_BEEF);

    drive(1'b0, W, 1'b0, 11'h010, 32'h0);
    chk("rst load valid pre", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rst load valid", 32'(rsp_valid), 32'd0);
    chk("rst load rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst ready", 32'(req_ready), 32'd1);
`endif

    for (int i = 0; i < 8; i++) begin
      st($sformatf("stream sw %0d", i), W, 11'h040 + 11'(4 * i), 32'h0101_0101 * 32'(i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      ld($sformatf("stream lw %0d", i), W, 1'b0, 11'h040 + 11'(4 * i), 32'h0101_0101 * 32'(i + 1));
    end
    @(posedge clk);
    #1;
    chk("stream idle", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
